kmeans_accum_ctrl: RTL and testbench

//  Initiator-side controller for the true dual-port `memory` block (DATA_WIDTH/ADDR_WIDTH matched).

---
 rtl/kmeans_accum_ctrl_pkg.sv | 16 +
 rtl/kmeans_accum_ctrl_if.sv | 42 ++++
 rtl/kmeans_accum.sv | 165 ++++++++++++++++
 tb/tb_kmeans_accum_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_accum_ctrl_pkg.sv
// Shared types and defaults for the k-means per-cluster accumulator controller
// and for other users of the same accumulator RAM.
package kmeans_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN
  } state_t;

  localparam int unsigned KM_DATA_WIDTH  = 32;
  localparam int unsigned KM_ADDR_WIDTH  = 9;
  localparam int unsigned KM_NUM_ENTRIES = 512;

endpackage

// File: rtl/kmeans_accum_ctrl_if.sv
// Beat stream in, drain stream out, and the two RAM ports of the accumulator
// controller. The master side is the controller.
interface kmeans_accum_ctrl_if
  import kmeans_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = KM_ADDR_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_id;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic [DATA_WIDTH-1:0] mem_data_a;
  logic                  mem_we_a;
  logic [DATA_WIDTH-1:0] mem_q_a;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic [DATA_WIDTH-1:0] mem_data_b;
  logic                  mem_we_b;
  logic [DATA_WIDTH-1:0] mem_q_b;

  modport master (
    input  in_valid, in_id, in_data, in_last, out_ready, mem_q_a, mem_q_b,
    output in_ready, out_valid, out_addr, out_data, out_last,
    output mem_addr_a, mem_data_a, mem_we_a, mem_addr_b, mem_data_b, mem_we_b
  );

  modport slave (
    output in_valid, in_id, in_data, in_last, out_ready, mem_q_a, mem_q_b,
    input  in_ready, out_valid, out_addr, out_data, out_last,
    input  mem_addr_a, mem_data_a, mem_we_a, mem_addr_b, mem_data_b, mem_we_b
  );

endinterface

// File: rtl/kmeans_accum.sv
// Per-cluster accumulator controller: clears, read-modify-write accumulates and
// drains a dual-port RAM (port A reads, port B writes).
module kmeans_accum_ctrl
  import kmeans_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = KM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = KM_ADDR_WIDTH,
  parameter int unsigned NUM_ENTRIES = KM_NUM_ENTRIES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_clear,
  input  logic cmd_accum,
  input  logic cmd_drain,
  output logic busy,
  output logic done,
  kmeans_accum_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ENTRIES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  out_valid_q, out_valid_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_last_q, s1_last_d;
  logic [ADDR_WIDTH-1:0] s1_id_q, s1_id_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  rec_valid_q;
  logic [ADDR_WIDTH-1:0] rec_addr_q;
  logic [DATA_WIDTH-1:0] rec_data_q;

  logic                  in_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_b;

  // The RAM returns pre-write data when port A reads the address port B writes
  // on the same edge, so the last write is forwarded from the record instead.
  assign operand = (rec_valid_q && (rec_addr_q == s1_id_q)) ? rec_data_q : bus.mem_q_a;
  assign sum     = operand + s1_data_q;
  assign accept  = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    s1_valid_d  = 1'b0;
    s1_last_d   = 1'b0;
    s1_id_d     = s1_id_q;
    s1_data_d   = s1_data_q;
    in_ready    = 1'b0;
    addr_a      = '0;
    we_b        = 1'b0;
    addr_b      = '0;
    data_b      = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (cmd_accum) begin
          state_d = ST_ACCUM;
        end else if (cmd_drain) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        we_b   = 1'b1;
        addr_b = cnt_q;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_ACCUM: begin
        in_ready = !(s1_valid_q && s1_last_q);
        addr_a   = bus.in_id;
        if (accept) begin
          s1_valid_d = 1'b1;
          s1_last_d  = bus.in_last;
          s1_id_d    = bus.in_id;
          s1_data_d  = bus.in_data;
        end
        if (s1_valid_q) begin
          we_b   = 1'b1;
          addr_b = s1_id_q;
          data_b = sum;
          if (s1_last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        addr_a      = cnt_q;
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_id_q     <= '0;
      s1_data_q   <= '0;
      rec_valid_q <= 1'b0;
      rec_addr_q  <= '0;
      rec_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_id_q     <= s1_id_d;
      s1_data_q   <= s1_data_d;
      rec_valid_q <= we_b;
      rec_addr_q  <= addr_b;
      rec_data_q  <= data_b;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = cnt_q;
  assign bus.out_data   = bus.mem_q_a;
  assign bus.out_last   = out_valid_q && (cnt_q == LAST_IDX);
  assign bus.mem_addr_a = addr_a;
  assign bus.mem_data_a = '0;
  assign bus.mem_we_a   = 1'b0;
  assign bus.mem_addr_b = addr_b;
  assign bus.mem_data_b = data_b;
  assign bus.mem_we_b   = we_b;

endmodule

// File: tb/tb_kmeans_accum_ctrl.sv
// Bench for kmeans_accum_ctrl: behavioural dual-port RAM, reference copy of the
// table, and a drain scoreboard filled from that copy.
module tb_kmeans_accum_ctrl;
  import kmeans_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned NE = 512;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_clear = 1'b0;
  logic cmd_accum = 1'b0;
  logic cmd_drain = 1'b0;
  logic busy;
  logic done;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  logic [DW-1:0] ram   [NE];
  logic [DW-1:0] model [NE];
  exp_t          exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  kmeans_accum_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  kmeans_accum_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_ENTRIES(NE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_clear(cmd_clear),
    .cmd_accum(cmd_accum),
    .cmd_drain(cmd_drain),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM: a same-edge read of a written address sees old data.
  always @(posedge clk) begin
    bus.mem_q_a <= ram[bus.mem_addr_a];
    bus.mem_q_b <= ram[bus.mem_addr_b];
    if (bus.mem_we_a) ram[bus.mem_addr_a] <= bus.mem_data_a;
    if (bus.mem_we_b) ram[bus.mem_addr_b] <= bus.mem_data_b;
    if (pre_we)       ram[pre_addr]       <= pre_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned which);
    cmd_clear = (which == 0);
    cmd_accum = (which == 1);
    cmd_drain = (which == 2);
    tick();
    cmd_clear = 1'b0;
    cmd_accum = 1'b0;
    cmd_drain = 1'b0;
  endtask

  task automatic do_clear();
    int unsigned n;
    pulse(0);
    check("clear_busy", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < NE + 10) begin
      tick();
      n++;
    end
    check("clear_done", done, 1);
    check("clear_cycles", n, NE);
    check("clear_idle", busy, 0);
    for (int unsigned i = 0; i < NE; i++) model[i] = '0;
  endtask

  task automatic send_beat(input logic [AW-1:0] id, input logic [DW-1:0] data, input logic last);
    int unsigned n;
    bus.in_valid = 1'b1;
    bus.in_id    = id;
    bus.in_data  = data;
    bus.in_last  = last;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("beat_ready", bus.in_ready, 1);
    if (bus.in_ready === 1'b1) begin
      tick();
      model[id] = model[id] + data;
      if (last) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("ready_drop", bus.in_ready, 0);
        check("last_write_we", bus.mem_we_b, 1);
        tick();
        check("accum_done", done, 1);
        check("accum_idle", busy, 0);
      end
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_drain(input int stall_addr);
    int unsigned n;
    int unsigned stalls;
    exp_t e;
    for (int unsigned i = 0; i < NE; i++)
      exp_q.push_back('{addr: AW'(i), data: model[i], last: (i == NE - 1)});
    pulse(2);
    check("drain_first_valid", bus.out_valid, 0);
    n = 0;
    stalls = 0;
    while (exp_q.size() > 0 && n < 4 * NE + 50) begin
      bus.out_ready = 1'b0;
      if (bus.out_valid === 1'b1) begin
        e = exp_q[0];
        if (int'(e.addr) == stall_addr && stalls < 5) begin
          stalls++;
          check("stall_addr", bus.out_addr, e.addr);
          check("stall_data", bus.out_data, e.data);
        end else begin
          bus.out_ready = 1'b1;
          check("drain_addr", bus.out_addr, e.addr);
          check("drain_data", bus.out_data, e.data);
          check("drain_last", bus.out_last, e.last);
          void'(exp_q.pop_front());
        end
      end
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    if (stall_addr >= 0) check("stall_cycles", stalls, 5);
    check("drain_done", done, 1);
    check("drain_idle", busy, 0);
    check("drain_valid_low", bus.out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_id     = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) tick();
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last",  bus.out_last, 0);
    check("rst_we_b",      bus.mem_we_b, 0);
    check("rst_we_a",      bus.mem_we_a, 0);
    check("rst_addr_a",    bus.mem_addr_a, 0);
    check("rst_addr_b",    bus.mem_addr_b, 0);
    check("rst_data_b",    bus.mem_data_b, 0);
    check("rst_data_a",    bus.mem_data_a, 0);
    rst_n = 1'b1;
    tick();

    // 1: clear then drain zeros
    do_clear();
    do_drain(-1);

    // 2: scattered beats
    pulse(1);
    check("accum_busy", busy, 1);
    send_beat(AW'(3), DW'(5),  1'b0);
    send_beat(AW'(7), DW'(2),  1'b0);
    send_beat(AW'(3), DW'(10), 1'b1);
    do_drain(-1);

    // 3: back-to-back same id exercises the write-forwarding path
    pulse(1);
    for (int unsigned i = 0; i < 4; i++) send_beat(AW'(9), DW'(1), (i == 3));
    do_drain(-1);

    // 4+5: wraparound, then drain with a 5-cycle stall on entry 4
    pre_we   = 1'b1;
    pre_addr = AW'(1);
    pre_data = '1;
    tick();
    pre_we   = 1'b0;
    model[1] = '1;
    pulse(1);
    send_beat(AW'(1), DW'(2), 1'b1);
    do_drain(4);

    // commands outside IDLE are ignored: drain pulse during clear
    pulse(0);
    cmd_drain = 1'b1;
    tick();
    cmd_drain = 1'b0;
    check("ignored_cmd_we", bus.mem_we_b, 1);
    repeat (NE) tick();
    check("ignored_cmd_idle", busy, 0);
    for (int unsigned i = 0; i < NE; i++) model[i] = '0;

    // 6: reset in the middle of an accumulate pass
    pulse(1);
    bus.in_valid = 1'b1;
    bus.in_id    = AW'(5);
    bus.in_data  = DW'(7);
    bus.in_last  = 1'b0;
    tick();
    check("s1_we_b", bus.mem_we_b, 1);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("midrst_we_b",     bus.mem_we_b, 0);
    check("midrst_busy",     busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    tick();
    do_clear();
    do_drain(-1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
